// File: rtl/avalon_st_pkt_enforcer_if.sv
// Avalon-ST stream bundle: valid/ready handshake plus sop/eop framing, data and empty.
// No logic of its own; latency is set by whichever module drives it.
// The ready signal flows from slave to master; all other signals flow master to slave.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic          valid;
    logic          ready;
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;

    modport master (output valid, sop, eop, data, empty, input ready);
    modport slave  (input valid, sop, eop, data, empty, output ready);
endinterface

// File: rtl/avalon_st_pkt_enforcer.sv
// Purpose: repairs sop/eop framing from an untrusted Avalon-ST source; flags and counts errors.
// Latency: one cycle through a single output register; dropped beats produce no output.
// Backpressure: input ready = output empty or downstream ready; dropped beats are still accepted.
module avalon_st_pkt_enforcer #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_PKT_BEATS       = 256,
    parameter int ERR_CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    avalon_st_if.slave               untrusted_msg,
    avalon_st_if.master              enforced_msg,
    input  logic                     clear_counters,
    output logic                     missing_sop_error,
    output logic                     double_sop_error,
    output logic                     oversize_error,
    output logic [ERR_CNT_WIDTH-1:0] missing_sop_cnt,
    output logic [ERR_CNT_WIDTH-1:0] double_sop_cnt,
    output logic [ERR_CNT_WIDTH-1:0] oversize_cnt
);
    localparam int DW    = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW    = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam int CNT_W = $clog2(MAX_PKT_BEATS) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_IN_PKT, ST_DISCARD} state_t;

    state_t             r_state, w_next_state;
    logic [CNT_W-1:0]   r_beat_cnt, w_next_cnt;
    logic               r_vld, r_sop, r_eop;
    logic [DW-1:0]      r_data;
    logic [EW-1:0]      r_empty;
    logic               r_ms_err, r_ds_err, r_ov_err;
    logic [ERR_CNT_WIDTH-1:0] r_ms_cnt, r_ds_cnt, r_ov_cnt;

    logic               w_in_rdy, w_accept, w_drop;
    logic               w_out_sop, w_out_eop;
    logic [EW-1:0]      w_out_empty;
    logic               w_ms_err, w_ds_err, w_ov_err;

    assign w_in_rdy            = ~r_vld | enforced_msg.ready;
    assign w_accept            = untrusted_msg.valid & w_in_rdy;
    assign untrusted_msg.ready = w_in_rdy;

    assign enforced_msg.valid  = r_vld;
    assign enforced_msg.sop    = r_sop;
    assign enforced_msg.eop    = r_eop;
    assign enforced_msg.data   = r_data;
    assign enforced_msg.empty  = r_empty;

    assign missing_sop_error   = r_ms_err;
    assign double_sop_error    = r_ds_err;
    assign oversize_error      = r_ov_err;
    assign missing_sop_cnt     = r_ms_cnt;
    assign double_sop_cnt      = r_ds_cnt;
    assign oversize_cnt        = r_ov_cnt;

    // Framing state and beats-in-packet counter advance only on accepted beats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_beat_cnt <= w_next_cnt;
        end
    end

    // Classify the accepted beat: pass, rewrite framing, or drop, and pick the error it raises.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_beat_cnt;
        w_drop       = 1'b0;
        w_out_sop    = untrusted_msg.sop;
        w_out_eop    = untrusted_msg.eop;
        w_out_empty  = untrusted_msg.eop ? untrusted_msg.empty : '0;
        w_ms_err     = 1'b0;
        w_ds_err     = 1'b0;
        w_ov_err     = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (untrusted_msg.sop) begin
                        if (!untrusted_msg.eop) begin
                            w_next_cnt   = CNT_W'(1);
                            w_next_state = ST_IN_PKT;
                        end
                    end else begin
                        w_drop       = 1'b1;
                        w_ms_err     = 1'b1;
                        w_next_state = untrusted_msg.eop ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_IN_PKT: begin
                    // A new sop takes precedence over the length limit.
                    if (untrusted_msg.sop) begin
                        w_out_sop    = 1'b0;
                        w_out_eop    = 1'b1;
                        w_out_empty  = '0;
                        w_ds_err     = 1'b1;
                        w_next_state = untrusted_msg.eop ? ST_IDLE : ST_DISCARD;
                    end else if (untrusted_msg.eop) begin
                        w_next_state = ST_IDLE;
                    end else if (r_beat_cnt == CNT_W'(MAX_PKT_BEATS - 1)) begin
                        w_out_eop    = 1'b1;
                        w_out_empty  = '0;
                        w_ov_err     = 1'b1;
                        w_next_state = ST_DISCARD;
                    end else begin
                        w_next_cnt   = r_beat_cnt + CNT_W'(1);
                    end
                end
                ST_DISCARD: begin
                    w_drop = 1'b1;
                    if (untrusted_msg.eop) w_next_state = ST_IDLE;
                end
                default: begin
                    w_drop       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Output beat and error pulses share one load; flags clear whenever the register does not load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld    <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_data   <= '0;
            r_empty  <= '0;
            r_ms_err <= 1'b0;
            r_ds_err <= 1'b0;
            r_ov_err <= 1'b0;
        end else if (w_in_rdy) begin
            r_vld    <= w_accept & ~w_drop;
            r_sop    <= w_accept & ~w_drop & w_out_sop;
            r_eop    <= w_accept & ~w_drop & w_out_eop;
            r_data   <= untrusted_msg.data;
            r_empty  <= w_out_empty;
            r_ms_err <= w_ms_err;
            r_ds_err <= w_ds_err;
            r_ov_err <= w_ov_err;
        end else begin
            r_ms_err <= 1'b0;
            r_ds_err <= 1'b0;
            r_ov_err <= 1'b0;
        end
    end

    // Saturating error counters; a clear wins over an error in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst || clear_counters) begin
            r_ms_cnt <= '0;
            r_ds_cnt <= '0;
            r_ov_cnt <= '0;
        end else begin
            if (w_ms_err && (r_ms_cnt != '1)) r_ms_cnt <= r_ms_cnt + 1'b1;
            if (w_ds_err && (r_ds_cnt != '1)) r_ds_cnt <= r_ds_cnt + 1'b1;
            if (w_ov_err && (r_ov_cnt != '1)) r_ov_cnt <= r_ov_cnt + 1'b1;
        end
    end
endmodule
